// File: rtl/clock_divider_prog_pkg.sv
// Shared definitions for the programmable clock divider: FSM state encoding and divider limits.
package clock_divider_prog_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StHold  = 2'd3
  } clkdiv_state_e;

  localparam int unsigned CLKDIV_MIN_DIV = 1;

endpackage

// File: rtl/clock_divider_prog_step_edge_det.sv
// Two-flop synchroniser plus rising-edge pulse for the debug single-step request.
module clock_divider_prog_step_edge_det (
  input  logic clkf_i,
  input  logic rst_i,
  input  logic req_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clkf_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= req_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable, glitch-free clock divider with edge ticks.
// Define CLKDIV_SINGLE_STEP_EN to enable the debug single-step HOLD state.
module clock_divider_prog
  import clock_divider_prog_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DEF_DIV   = 4,
  parameter bit          RST_LEVEL = 1'b1
) (
  input  logic             clkf,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] div_half,
  input  logic             div_load,
  input  logic             step_mode,
  input  logic             step_req,
  output logic             clk,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             busy,
  output logic [CNT_W-1:0] div_cur
);

  localparam logic REST = RST_LEVEL;

  clkdiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] div_norm;
  logic             boundary;
  logic             counting;
  logic             step_pulse;
  logic             hold_req;

`ifdef CLKDIV_SINGLE_STEP_EN
  clock_divider_prog_step_edge_det u_step_edge_det (
    .clkf_i  (clkf),
    .rst_i   (rst),
    .req_i   (step_req),
    .pulse_o (step_pulse)
  );
  assign hold_req = step_mode;
`else
  logic unused_step;
  assign unused_step = step_mode ^ step_req;
  assign step_pulse  = 1'b0;
  assign hold_req    = 1'b0;
`endif

  assign div_norm = (div_half == '0) ? CNT_W'(CLKDIV_MIN_DIV) : div_half;
  assign counting = (state_q == StRun) || (state_q == StDrain);
  assign boundary = counting && (cnt_q == div_cur_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    unique case (state_q)
      StIdle: begin
        clk_d = REST;
        cnt_d = '0;
        if (start) state_d = StRun;
      end
      StRun, StDrain: begin
        if (boundary) begin
          cnt_d = '0;
          clk_d = ~clk_q;
          // Stop or park only on the edge that lands back on the rest level.
          if (~clk_q == REST) begin
            if (!start)        state_d = StIdle;
            else if (hold_req) state_d = StHold;
            else               state_d = StRun;
          end else begin
            state_d = start ? StRun : StDrain;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = start ? StRun : StDrain;
        end
      end
      StHold: begin
        clk_d = REST;
        cnt_d = '0;
        if (!start)                       state_d = StIdle;
        else if (!hold_req || step_pulse) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  // Ratio changes only land on a boundary so no half-period is cut short or stretched.
  always_comb begin
    div_cur_d  = div_cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (counting) begin
      if (div_load) begin
        if (boundary) begin
          div_cur_d  = div_norm;
          pend_vld_d = 1'b0;
        end else begin
          pend_d     = div_norm;
          pend_vld_d = 1'b1;
        end
      end else if (boundary && pend_vld_q) begin
        div_cur_d  = pend_q;
        pend_vld_d = 1'b0;
      end
    end else if (div_load) begin
      div_cur_d  = div_norm;
      pend_vld_d = 1'b0;
    end else if (pend_vld_q) begin
      div_cur_d  = pend_q;
      pend_vld_d = 1'b0;
    end
  end

  assign rise_d = clk_d & ~clk_q;
  assign fall_d = ~clk_d & clk_q;

  always_ff @(posedge clkf or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_cur_q  <= CNT_W'(DEF_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= REST;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign clk       = clk_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
  assign busy      = (state_q != StIdle);
  assign div_cur   = div_cur_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed self-checking bench for clock_divider_prog (default parameters).
module tb_clock_divider_prog;

  logic       clkf = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] div_half = 8'd0;
  logic       div_load = 1'b0;
  logic       step_mode = 1'b0;
  logic       step_req = 1'b0;
  logic       clk, rise_tick, fall_tick, busy;
  logic [7:0] div_cur;

  int checks = 0;
  int errors = 0;

  clock_divider_prog dut (
    .clkf      (clkf),
    .rst       (rst),
    .start     (start),
    .div_half  (div_half),
    .div_load  (div_load),
    .step_mode (step_mode),
    .step_req  (step_req),
    .clk       (clk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .busy      (busy),
    .div_cur   (div_cur)
  );

  always #5 clkf = ~clkf;

  task automatic tick();
    @(posedge clkf);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; div_load = 1'b0; step_mode = 1'b0; step_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    tick();
    tick();
    checks++; if (clk !== 1'b1) begin errors++; $display("FAIL reset_clk got=%b exp=1", clk); end
    checks++; if (rise_tick !== 1'b0 || fall_tick !== 1'b0) begin
      errors++; $display("FAIL reset_ticks got=%b%b exp=00", rise_tick, fall_tick); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (div_cur !== 8'd4) begin errors++; $display("FAIL reset_div got=%0d exp=4", div_cur); end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      logic ec, er, ef;
      tick();
      ec = (k < 4) ? 1'b1 : ((((k - 4) / 4) % 2) == 0 ? 1'b0 : 1'b1);
      ef = (k >= 4) && ((k - 4) % 8 == 0);
      er = (k >= 4) && ((k - 4) % 8 == 4);
      checks++; if (clk !== ec) begin errors++; $display("FAIL run_clk k=%0d got=%b exp=%b", k, clk, ec); end
      checks++; if (fall_tick !== ef || rise_tick !== er) begin
        errors++; $display("FAIL run_ticks k=%0d got=%b%b exp=%b%b", k, rise_tick, fall_tick, er, ef); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy k=%0d got=%b exp=1", k, busy); end
    end
  endtask

  task automatic test_ratio_change();
    do_reset();
    start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic ec;
      logic [7:0] ed;
      div_load = (k == 5) || (k == 6);
      div_half = (k == 5) ? 8'd6 : 8'd2;
      tick();
      div_load = 1'b0;
      if (k < 8) ec = (k < 4) ? 1'b1 : 1'b0;
      else       ec = ((((k - 8) / 2) % 2) == 0) ? 1'b1 : 1'b0;
      ed = (k < 8) ? 8'd4 : 8'd2;
      checks++; if (clk !== ec) begin errors++; $display("FAIL ratio_clk k=%0d got=%b exp=%b", k, clk, ec); end
      checks++; if (div_cur !== ed) begin errors++; $display("FAIL ratio_div k=%0d got=%0d exp=%0d", k, div_cur, ed); end
      checks++; if (rise_tick && fall_tick) begin errors++; $display("FAIL ratio_both k=%0d got=11 exp=not11", k); end
    end
  endtask

  task automatic test_load_boundary();
    do_reset();
    start = 1'b1;
    for (int k = 0; k < 13; k++) begin
      logic ec;
      logic [7:0] ed;
      div_load = (k == 4);
      div_half = 8'd3;
      tick();
      div_load = 1'b0;
      ec = (k < 4) ? 1'b1 : ((((k - 4) / 3) % 2) == 0 ? 1'b0 : 1'b1);
      ed = (k < 4) ? 8'd4 : 8'd3;
      checks++; if (clk !== ec) begin errors++; $display("FAIL bnd_clk k=%0d got=%b exp=%b", k, clk, ec); end
      checks++; if (div_cur !== ed) begin errors++; $display("FAIL bnd_div k=%0d got=%0d exp=%0d", k, div_cur, ed); end
    end
  endtask

  task automatic test_div_zero();
    do_reset();
    div_half = 8'd0; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    checks++; if (div_cur !== 8'd1) begin errors++; $display("FAIL zero_div got=%0d exp=1", div_cur); end
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic ec, er, ef;
      tick();
      ec = (k == 0) ? 1'b1 : ((k % 2 == 1) ? 1'b0 : 1'b1);
      ef = (k % 2 == 1);
      er = (k >= 2) && (k % 2 == 0);
      checks++; if (clk !== ec) begin errors++; $display("FAIL zero_clk k=%0d got=%b exp=%b", k, clk, ec); end
      checks++; if (fall_tick !== ef || rise_tick !== er) begin
        errors++; $display("FAIL zero_ticks k=%0d got=%b%b exp=%b%b", k, rise_tick, fall_tick, er, ef); end
    end
  endtask

  task automatic test_stop();
    do_reset();
    start = 1'b1;
    for (int k = 0; k < 14; k++) begin
      logic ec, eb;
      start = (k < 5);
      tick();
      ec = (k >= 4 && k < 8) ? 1'b0 : 1'b1;
      eb = (k < 8);
      checks++; if (clk !== ec) begin errors++; $display("FAIL stop_clk k=%0d got=%b exp=%b", k, clk, ec); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL stop_busy k=%0d got=%b exp=%b", k, busy, eb); end
      checks++; if (rise_tick !== (k == 8)) begin
        errors++; $display("FAIL stop_rise k=%0d got=%b exp=%b", k, rise_tick, (k == 8)); end
    end
    // Drop start for one cycle only: the running phase must be undisturbed.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      logic ec;
      start = (k != 5);
      tick();
      ec = (k < 4) ? 1'b1 : ((((k - 4) / 4) % 2) == 0 ? 1'b0 : 1'b1);
      checks++; if (clk !== ec) begin errors++; $display("FAIL resume_clk k=%0d got=%b exp=%b", k, clk, ec); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL resume_busy k=%0d got=%b exp=1", k, busy); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    div_half = 8'd3; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    checks++; if (clk !== 1'b0 || fall_tick !== 1'b1) begin
      errors++; $display("FAIL arst_pre got=%b%b exp=01", clk, fall_tick); end
    #1 rst = 1'b1;
    #1;
    checks++; if (clk !== 1'b1) begin errors++; $display("FAIL arst_clk got=%b exp=1", clk); end
    checks++; if (rise_tick !== 1'b0 || fall_tick !== 1'b0) begin
      errors++; $display("FAIL arst_ticks got=%b%b exp=00", rise_tick, fall_tick); end
    checks++; if (div_cur !== 8'd4) begin errors++; $display("FAIL arst_div got=%0d exp=4", div_cur); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", busy); end
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      logic ec;
      tick();
      ec = (k < 4) ? 1'b1 : 1'b0;
      checks++; if (clk !== ec) begin errors++; $display("FAIL arst_run k=%0d got=%b exp=%b", k, clk, ec); end
    end
  endtask

  task automatic test_step();
    int falls, rises, lows;
    do_reset();
    div_half = 8'd3; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    start = 1'b1; step_mode = 1'b1;
`ifdef CLKDIV_SINGLE_STEP_EN
    falls = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (fall_tick) falls++;
    end
    checks++; if (falls != 1) begin errors++; $display("FAIL hold_falls got=%0d exp=1", falls); end
    checks++; if (clk !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL hold_park got=%b%b exp=11", clk, busy); end
    for (int s = 0; s < 3; s++) begin
      falls = 0; rises = 0; lows = 0;
      step_req = 1'b1;
      tick();
      tick();
      step_req = 1'b0;
      for (int k = 0; k < 18; k++) begin
        tick();
        if (fall_tick) falls++;
        if (rise_tick) rises++;
        if (!clk) lows++;
      end
      checks++; if (lows != 3) begin errors++; $display("FAIL step_low s=%0d got=%0d exp=3", s, lows); end
      checks++; if (falls != 1 || rises != 1) begin
        errors++; $display("FAIL step_edges s=%0d got=%0d/%0d exp=1/1", s, falls, rises); end
      checks++; if (clk !== 1'b1) begin errors++; $display("FAIL step_end s=%0d got=%b exp=1", s, clk); end
    end
    step_mode = 1'b0;
`endif
    falls = 0;
    for (int k = 0; k < 20; k++) begin
      step_req = k[0];
      tick();
      if (fall_tick) falls++;
    end
    step_req = 1'b0;
    checks++; if (falls != 3) begin errors++; $display("FAIL freerun_falls got=%0d exp=3", falls); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL freerun_busy got=%b exp=1", busy); end
  endtask

  initial begin
    test_reset();
    test_ratio_change();
    test_load_boundary();
    test_div_zero();
    test_stop();
    test_async_reset();
    test_step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
